// File: rtl/key_repeat_ctrl.sv
// rtl/key_repeat_ctrl.sv - per-channel button debounce with auto-repeat press pulses
module key_repeat_ctrl #(
  parameter int             N             = 3,
  parameter int             DEBOUNCE      = 4,
  parameter int             REPEAT_DELAY  = 30,
  parameter int             REPEAT_PERIOD = 8,
  parameter logic [N-1:0]   REPEAT_MASK   = 3'b011
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick,
  input  logic [N-1:0] btn_in,
  output logic [N-1:0] held,
  output logic [N-1:0] press
);

  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW   = $clog2(DEBOUNCE + 1);
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);
  localparam logic [TW-1:0] DLY_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PER_LAST = TW'(REPEAT_PERIOD - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DELAY  = 2'd1;
  localparam logic [1:0] REPEAT = 2'd2;

  logic [CW-1:0] cnt   [N];
  logic [CW-1:0] cnt_d [N];
  logic [TW-1:0] tmr   [N];
  logic [TW-1:0] tmr_d [N];
  logic [1:0]    st    [N];
  logic [1:0]    st_d  [N];
  logic [N-1:0]  held_d;
  logic [N-1:0]  pulse;

  always_comb begin
    held_d = held;
    pulse  = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt[i];
      tmr_d[i] = tmr[i];
      st_d[i]  = st[i];
      if (tick) begin
        if (btn_in[i] == held[i]) begin
          cnt_d[i] = '0;
        end else if (cnt[i] == CNT_LAST) begin
          held_d[i] = btn_in[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt[i] + 1'b1;
        end

        // FSM sees this tick's debounced level; release wins over timer expiry
        case (st[i])
          IDLE: begin
            if (held_d[i] && !held[i]) begin
              pulse[i] = 1'b1;
              tmr_d[i] = '0;
              st_d[i]  = DELAY;
            end
          end
          DELAY: begin
            if (!held_d[i]) begin
              st_d[i]  = IDLE;
              tmr_d[i] = '0;
            end else if (REPEAT_MASK[i]) begin
              if (tmr[i] == DLY_LAST) begin
                pulse[i] = 1'b1;
                tmr_d[i] = '0;
                st_d[i]  = REPEAT;
              end else begin
                tmr_d[i] = tmr[i] + 1'b1;
              end
            end
          end
          REPEAT: begin
            if (!held_d[i]) begin
              st_d[i]  = IDLE;
              tmr_d[i] = '0;
            end else if (tmr[i] == PER_LAST) begin
              pulse[i] = 1'b1;
              tmr_d[i] = '0;
            end else begin
              tmr_d[i] = tmr[i] + 1'b1;
            end
          end
          default: begin
            st_d[i]  = IDLE;
            tmr_d[i] = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      held  <= '0;
      press <= '0;
      for (int i = 0; i < N; i++) begin
        cnt[i] <= '0;
        tmr[i] <= '0;
        st[i]  <= IDLE;
      end
    end else begin
      held  <= held_d;
      press <= pulse;
      for (int i = 0; i < N; i++) begin
        cnt[i] <= cnt_d[i];
        tmr[i] <= tmr_d[i];
        st[i]  <= st_d[i];
      end
    end
  end

endmodule

// File: tb/tb_key_repeat_ctrl.sv
// tb/tb_key_repeat_ctrl.sv - scoreboard bench for key_repeat_ctrl against a tick-count model
module tb_key_repeat_ctrl;

  localparam int           N    = 3;
  localparam int           DEB  = 2;
  localparam int           RD   = 4;
  localparam int           RP   = 2;
  localparam logic [N-1:0] MASK = 3'b011;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         tick = 1'b0;
  logic [N-1:0] btn_in = '0;
  logic [N-1:0] held;
  logic [N-1:0] press;

  int checks = 0;
  int errors = 0;

  logic [2*N-1:0] exp_q[$];

  // model: debounced level, run of differing ticks, ticks since the accepted press (-1 = released)
  logic [N-1:0] m_held = '0;
  logic [N-1:0] m_press = '0;
  int           m_diff[N];
  int           m_k[N];

  key_repeat_ctrl #(
    .N(N), .DEBOUNCE(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_MASK(MASK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .btn_in(btn_in), .held(held), .press(press)
  );

  always #5 clk = ~clk;

  task automatic model_update(input logic [N-1:0] b, input logic t, input logic r);
    logic prev;
    m_press = '0;
    for (int i = 0; i < N; i++) begin
      if (!r) begin
        m_held[i] = 1'b0;
        m_diff[i] = 0;
        m_k[i]    = -1;
      end else if (t) begin
        prev = m_held[i];
        if (b[i] != m_held[i]) begin
          m_diff[i]++;
          if (m_diff[i] >= DEB) begin
            m_held[i] = b[i];
            m_diff[i] = 0;
          end
        end else begin
          m_diff[i] = 0;
        end
        if (m_held[i]) begin
          if (!prev) begin
            m_k[i] = 0;
            m_press[i] = 1'b1;
          end else begin
            m_k[i]++;
            m_press[i] = MASK[i] && m_k[i] >= RD && ((m_k[i] - RD) % RP) == 0;
          end
        end else begin
          m_k[i] = -1;
        end
      end
    end
  endtask

  task automatic step(input logic [N-1:0] b, input logic t, input logic r);
    @(negedge clk);
    btn_in = b;
    tick   = t;
    rst_n  = r;
    model_update(b, t, r);
    exp_q.push_back({m_held, m_press});
  endtask

  // one logical tick spread over div cycles, tick on the last one
  task automatic tick_step(input logic [N-1:0] b, input int div);
    for (int c = 0; c < div; c++) step(b, (c == div - 1), 1'b1);
  endtask

  task automatic hold_run(input int ch, input int hi, input int lo, input int div);
    logic [N-1:0] b;
    b = '0;
    b[ch] = 1'b1;
    for (int t = 0; t < hi; t++) tick_step(b, div);
    for (int t = 0; t < lo; t++) tick_step('0, div);
  endtask

  always @(posedge clk) begin
    logic [2*N-1:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (held !== e[2*N-1:N]) begin
        errors++;
        $display("FAIL held at %0t: got %b expected %b", $time, held, e[2*N-1:N]);
      end
      checks++;
      if (press !== e[N-1:0]) begin
        errors++;
        $display("FAIL press at %0t: got %b expected %b", $time, press, e[N-1:0]);
      end
    end
  end

  initial begin
    logic [N-1:0] rb;
    int           wait_cnt;
    for (int i = 0; i < N; i++) begin
      m_diff[i] = 0;
      m_k[i]    = -1;
    end

    for (int c = 0; c < 3; c++) step('0, 1'b1, 1'b0);

    hold_run(0, 1, 6, 1);
    hold_run(0, 12, 6, 1);
    hold_run(2, 12, 6, 1);
    hold_run(1, 12, 6, 3);
    hold_run(0, 8, 6, 1);

    for (int t = 0; t < 9; t++) tick_step(3'b001, 1);
    step(3'b001, 1'b1, 1'b0);
    for (int t = 0; t < 8; t++) tick_step(3'b001, 1);
    for (int t = 0; t < 4; t++) tick_step('0, 1);

    rb = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) rb[i] = ~rb[i];
      step(rb, ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) != 0));
    end
    for (int c = 0; c < 8; c++) step('0, 1'b1, 1'b1);

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
